// File: rtl/i2c_scl_gen.sv
// I2C SCL generator: four quarter-period phases per SCL period, registered strobes,
// and clock-stretch freeze of the high-first-half phase.
`timescale 1ns/1ps
module i2c_scl_gen #(
    parameter int CNT_W      = 16,
    parameter bit STRETCH_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div,
    input  logic             scl_in,
    output logic             scl_o,
    output logic             scl_rise,
    output logic             scl_fall,
    output logic             sample_pt,
    output logic             change_pt,
    output logic             stretching
);

    typedef enum logic [1:0] {
        PH_LOW0  = 2'd0,
        PH_LOW1  = 2'd1,
        PH_HIGH0 = 2'd2,
        PH_HIGH1 = 2'd3
    } ph_t;

    ph_t              ph, ph_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] div_lat, div_lat_nxt;
    logic             active, active_nxt;
    logic [1:0]       sync;
    logic             scl_s;
    logic             fall_nxt, change_nxt, rise_nxt, sample_nxt, stretch_nxt;
    logic             tc, frozen;

    assign scl_s  = sync[1];
    assign tc     = (cnt == div_lat);
    assign frozen = STRETCH_EN && (ph == PH_HIGH0) && !scl_s;
    // ph is a flop, so its MSB is already a registered SCL level
    assign scl_o  = ph[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            ph         <= PH_HIGH1;
            div_lat    <= div;
            active     <= 1'b0;
            sync       <= 2'b11;
            scl_fall   <= 1'b0;
            change_pt  <= 1'b0;
            scl_rise   <= 1'b0;
            sample_pt  <= 1'b0;
            stretching <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            ph         <= ph_nxt;
            div_lat    <= div_lat_nxt;
            active     <= active_nxt;
            sync       <= {sync[0], scl_in};
            scl_fall   <= fall_nxt;
            change_pt  <= change_nxt;
            scl_rise   <= rise_nxt;
            sample_pt  <= sample_nxt;
            stretching <= stretch_nxt;
        end
    end

    always_comb begin
        cnt_nxt     = cnt;
        ph_nxt      = ph;
        div_lat_nxt = div_lat;
        active_nxt  = active;
        fall_nxt    = 1'b0;
        change_nxt  = 1'b0;
        rise_nxt    = 1'b0;
        sample_nxt  = 1'b0;
        stretch_nxt = 1'b0;
        if (!en) begin
            cnt_nxt     = '0;
            ph_nxt      = PH_HIGH1;
            div_lat_nxt = div;
            active_nxt  = 1'b0;
        end else if (!active) begin
            // The edge that first sees en only arms the counter, so the first
            // fall lands a full quarter (Q cycles) later.
            active_nxt  = 1'b1;
            cnt_nxt     = '0;
            div_lat_nxt = div;
        end else if (frozen) begin
            stretch_nxt = 1'b1;
        end else if (tc) begin
            cnt_nxt     = '0;
            ph_nxt      = ph_t'(ph + 2'd1);
            div_lat_nxt = div;
            case (ph)
                PH_HIGH1: fall_nxt   = 1'b1;
                PH_LOW0:  change_nxt = 1'b1;
                PH_LOW1:  rise_nxt   = 1'b1;
                default:  sample_nxt = 1'b1;
            endcase
        end else begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Self-checking bench for i2c_scl_gen: expected strobes are queued with their
// cycle stamps when stimulus is driven and popped as the DUT emits them.
`timescale 1ns/1ps
module tb_i2c_scl_gen;

    logic        clk = 1'b0;
    logic        rst, en, scl_in;
    logic [15:0] div;

    logic scl_o, scl_rise, scl_fall, sample_pt, change_pt, stretching;
    logic ns_scl_o, ns_scl_rise, ns_scl_fall, ns_sample_pt, ns_change_pt, ns_stretching;

    i2c_scl_gen #(.CNT_W(16), .STRETCH_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .div(div), .scl_in(scl_in),
        .scl_o(scl_o), .scl_rise(scl_rise), .scl_fall(scl_fall),
        .sample_pt(sample_pt), .change_pt(change_pt), .stretching(stretching)
    );

    i2c_scl_gen #(.CNT_W(16), .STRETCH_EN(1'b0)) dut_ns (
        .clk(clk), .rst(rst), .en(en), .div(div), .scl_in(scl_in),
        .scl_o(ns_scl_o), .scl_rise(ns_scl_rise), .scl_fall(ns_scl_fall),
        .sample_pt(ns_sample_pt), .change_pt(ns_change_pt), .stretching(ns_stretching)
    );

    always #5 clk = ~clk;

    // kind: 0 fall, 1 change, 2 rise, 3 sample
    typedef struct {
        int kind;
        int at;
    } ev_t;

    ev_t q[$];
    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;
    bit  mon_en  = 1'b0;
    bit  mon_sel = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [3:0] s;
        ev_t        e;
        if (mon_en) begin
            s = mon_sel ? {ns_sample_pt, ns_scl_rise, ns_change_pt, ns_scl_fall}
                        : {sample_pt, scl_rise, change_pt, scl_fall};
            for (int k = 0; k < 4; k++) begin
                if (s[k]) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL strobe_unexpected: kind %0d at cycle %0d, required none", k, cyc);
                    end else begin
                        e = q.pop_front();
                        if (e.kind != k || e.at != cyc) begin
                            errors++;
                            $display("FAIL strobe_order: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                                     k, cyc, e.kind, e.at);
                        end
                    end
                end
            end
        end
    end

    task automatic push_ev(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        q.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; div = 16'd1; scl_in = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (scl_o !== 1'b1 || stretching !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: scl_o=%b stretching=%b, required 1 0", scl_o, stretching);
        end
        checks++;
        if ({sample_pt, scl_rise, change_pt, scl_fall} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes: %b, required 0000", {sample_pt, scl_rise, change_pt, scl_fall});
        end
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (scl_o !== 1'b1 || {sample_pt, scl_rise, change_pt, scl_fall} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_over_en: scl_o=%b strobes=%b, required 1 0000",
                         scl_o, {sample_pt, scl_rise, change_pt, scl_fall});
            end
        end
        rst = 1'b0; en = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
    endtask

    task automatic test_period(input int dv);
        int  qq, c, f;
        logic exp_o;
        qq = dv + 1;
        mon_sel = 1'b0;
        div = 16'(dv);
        en  = 1'b1;
        c = cyc;
        f = c + 1 + qq;
        for (int p = 0; p < 12; p++) push_ev(p % 4, f + p * qq);
        for (int t = c + 1; t <= f + 11 * qq; t++) begin
            @(negedge clk);
            exp_o = (t < f) ? 1'b1 : ((((t - f) / qq) % 4) >= 2);
            checks++;
            if (scl_o !== exp_o) begin
                errors++;
                $display("FAIL period_scl_o div=%0d cycle %0d: got %b, required %b", dv, t, scl_o, exp_o);
            end
        end
        en = 1'b0;
        @(negedge clk);
        checks++;
        if (scl_o !== 1'b1) begin
            errors++;
            $display("FAIL period_idle div=%0d: scl_o=%b, required 1", dv, scl_o);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL period_missing div=%0d: %0d strobes not seen, required 0", dv, q.size());
            q.delete();
        end
    endtask

    task automatic test_stretch(input bit ns);
        int  c, f, r, smp, last;
        logic st, exp_st;
        mon_sel = ns;
        div = 16'd3;
        en  = 1'b1;
        c = cyc;
        f = c + 5;
        r = f + 8;
        smp  = ns ? r + 4 : r + 14;
        last = smp + 12;
        push_ev(0, f); push_ev(1, f + 4); push_ev(2, r);
        push_ev(3, smp); push_ev(0, smp + 4); push_ev(1, smp + 8); push_ev(2, smp + 12);
        for (int t = c + 1; t <= last; t++) begin
            @(negedge clk);
            st     = ns ? ns_stretching : stretching;
            exp_st = !ns && t >= r + 3 && t <= r + 12;
            checks++;
            if (st !== exp_st) begin
                errors++;
                $display("FAIL stretch_flag ns=%0d cycle %0d: got %b, required %b", ns, t, st, exp_st);
            end
            if (t == r)      scl_in = 1'b0;
            if (t == r + 10) scl_in = 1'b1;
        end
        en = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL stretch_missing ns=%0d: %0d strobes not seen, required 0", ns, q.size());
            q.delete();
        end
        mon_sel = 1'b0;
    endtask

    task automatic test_div_change();
        int  c, f;
        logic exp_o;
        div = 16'd1;
        en  = 1'b1;
        c = cyc;
        f = c + 3;
        push_ev(0, f); push_ev(1, f + 2); push_ev(2, f + 7); push_ev(3, f + 12);
        for (int t = c + 1; t <= f + 12; t++) begin
            @(negedge clk);
            if (t == f) div = 16'd4;
            if (t == f + 6 || t == f + 7) begin
                exp_o = (t == f + 7);
                checks++;
                if (scl_o !== exp_o) begin
                    errors++;
                    $display("FAIL div_change_scl_o cycle %0d: got %b, required %b", t, scl_o, exp_o);
                end
            end
        end
        en = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL div_change_missing: %0d strobes not seen, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_en_drop();
        int c, f;
        div = 16'd2;
        en  = 1'b1;
        c = cyc;
        f = c + 4;
        push_ev(0, f);
        for (int t = c + 1; t <= f + 2; t++) @(negedge clk);
        en = 1'b0;  // next edge is the change_pt terminal count
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (scl_o !== 1'b1 || stretching !== 1'b0) begin
                errors++;
                $display("FAIL en_drop_idle: scl_o=%b stretching=%b, required 1 0", scl_o, stretching);
            end
        end
        en = 1'b1;
        c = cyc;
        push_ev(0, c + 4); push_ev(1, c + 7);
        for (int t = c + 1; t <= c + 7; t++) begin
            @(negedge clk);
            if (t == c + 3 || t == c + 4) begin
                checks++;
                if (scl_o !== (t == c + 3)) begin
                    errors++;
                    $display("FAIL en_reenable_scl_o cycle %0d: got %b, required %b", t, scl_o, (t == c + 3));
                end
            end
        end
        en = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL en_drop_missing: %0d strobes not seen, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_rst_mid();
        int c, f, r, d;
        div = 16'd2;
        en  = 1'b1;
        c = cyc;
        f = c + 4;
        r = f + 6;
        push_ev(0, f); push_ev(1, f + 3); push_ev(2, r);
        for (int t = c + 1; t <= r + 1; t++) @(negedge clk);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (scl_o !== 1'b1 || stretching !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_state: scl_o=%b stretching=%b, required 1 0", scl_o, stretching);
            end
        end
        rst = 1'b0;
        d = cyc;
        push_ev(0, d + 4);
        for (int t = d + 1; t <= d + 4; t++) begin
            @(negedge clk);
            checks++;
            if (scl_o !== (t < d + 4)) begin
                errors++;
                $display("FAIL rst_restart_scl_o cycle %0d: got %b, required %b", t, scl_o, (t < d + 4));
            end
        end
        en = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL rst_mid_missing: %0d strobes not seen, required 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        int divs[3] = '{1, 0, 2};
        test_reset();
        foreach (divs[i]) test_period(divs[i]);
        test_stretch(1'b0);
        test_stretch(1'b1);
        test_div_change();
        test_en_drop();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
